// File: rtl/dout_arbiter.sv
// Round-robin scheduler sharing the 48-bit result word stream between NUM_SRC producers.
// Define DOUT_ARB_FIXED_PRIO_EN for fixed priority (lowest requesting index wins).
//
// state | meaning
// IDLE  | no packet held
// BEAT1 | packet latched, first word not yet written
// BEAT2 | packet latched, first word written, second pending

module dout_arbiter #(
  parameter int NUM_SRC = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      req,
  input  logic [NUM_SRC-1:0]      two_beat,
  input  logic [5*NUM_SRC-1:0]    src_hdr,
  input  logic [40*NUM_SRC-1:0]   src_hi,
  input  logic [40*NUM_SRC-1:0]   src_lo,
  input  logic                    full,
  output logic [NUM_SRC-1:0]      gnt,
  output logic [NUM_SRC-1:0]      done,
  output logic [47:0]             dataout,
  output logic                    wren
);

  localparam int IDX_W = $clog2(NUM_SRC);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d, idx_q, idx_d, win;
  logic               found;
  logic [4:0]         hdr_q, hdr_d;
  logic [39:0]        hi_q, hi_d, lo_q, lo_d;
  logic               two_q, two_d;
  logic [NUM_SRC-1:0] gnt_d, done_d;
  logic [47:0]        dataout_d;
  logic               wren_d;

  // Descending scan so the candidate nearest the search start is assigned last and wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
`ifdef DOUT_ARB_FIXED_PRIO_EN
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        win   = IDX_W'(i);
        found = 1'b1;
      end
    end
`else
    for (int i = NUM_SRC; i >= 1; i--) begin
      int cand;
      cand = (int'(last_q) + i) % NUM_SRC;
      if (req[cand]) begin
        win   = IDX_W'(cand);
        found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    idx_d     = idx_q;
    hdr_d     = hdr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    two_d     = two_q;
    gnt_d     = '0;
    done_d    = '0;
    wren_d    = 1'b0;
    dataout_d = dataout;
    case (state_q)
      IDLE: begin
        if (found) begin
          last_d     = win;
          idx_d      = win;
          hdr_d      = src_hdr[5*int'(win) +: 5];
          hi_d       = src_hi[40*int'(win) +: 40];
          lo_d       = src_lo[40*int'(win) +: 40];
          two_d      = two_beat[win];
          gnt_d[win] = 1'b1;
          state_d    = BEAT1;
        end
      end
      BEAT1: begin
        if (!full) begin
          wren_d    = 1'b1;
          dataout_d = {hdr_q, (two_q ? 3'b001 : 3'b000), hi_q};
          if (two_q) begin
            state_d = BEAT2;
          end else begin
            done_d[idx_q] = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      BEAT2: begin
        if (!full) begin
          wren_d        = 1'b1;
          dataout_d     = {hdr_q, 3'b010, lo_q};
          done_d[idx_q] = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_SRC - 1);
      idx_q   <= '0;
      hdr_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      two_q   <= 1'b0;
      gnt     <= '0;
      done    <= '0;
      dataout <= '0;
      wren    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      hdr_q   <= hdr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      two_q   <= two_d;
      gnt     <= gnt_d;
      done    <= done_d;
      dataout <= dataout_d;
      wren    <= wren_d;
    end
  end

endmodule

// File: tb/tb_dout_arbiter.sv
// Scoreboard bench for dout_arbiter: expected words and grants are queued as stimulus is driven.
// Build with DOUT_ARB_FIXED_PRIO_EN to check the fixed-priority variant.

module tb_dout_arbiter;

  logic         clk;
  logic         rst;
  logic [2:0]   req;
  logic [2:0]   two_beat;
  logic [14:0]  src_hdr;
  logic [119:0] src_hi;
  logic [119:0] src_lo;
  logic         full;
  logic [2:0]   gnt;
  logic [2:0]   done;
  logic [47:0]  dataout;
  logic         wren;

  logic [4:0]   hdr_t [3];
  logic [39:0]  hi_t  [3];
  logic [39:0]  lo_t  [3];

  typedef struct {
    logic [47:0] data;
    logic [2:0]  done;
  } exp_t;

  exp_t       exp_q [$];
  logic [2:0] gq    [$];
  int         wq    [$];
  exp_t       mon_e;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int rr_cnt = 0;
  logic hold_all = 1'b0;

  assign src_hdr = {hdr_t[2], hdr_t[1], hdr_t[0]};
  assign src_hi  = {hi_t[2], hi_t[1], hi_t[0]};
  assign src_lo  = {lo_t[2], lo_t[1], lo_t[0]};

  dout_arbiter #(.NUM_SRC(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .two_beat (two_beat),
    .src_hdr  (src_hdr),
    .src_hi   (src_hi),
    .src_lo   (src_lo),
    .full     (full),
    .gnt      (gnt),
    .done     (done),
    .dataout  (dataout),
    .wren     (wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  function automatic logic [47:0] mkw(logic [4:0] h, logic [2:0] b, logic [39:0] p);
    return {h, b, p};
  endfunction

  task automatic set_src(input int s, input logic [4:0] h, input logic tb,
                         input logic [39:0] hi, input logic [39:0] lo);
    hdr_t[s]    = h;
    hi_t[s]     = hi;
    lo_t[s]     = lo;
    two_beat[s] = tb;
  endtask

  task automatic push_pkt(input int s);
    logic [2:0] oh;
    oh = 3'b001 << s;
    gq.push_back(oh);
    if (two_beat[s]) begin
      exp_q.push_back('{mkw(hdr_t[s], 3'b001, hi_t[s]), 3'b000});
      exp_q.push_back('{mkw(hdr_t[s], 3'b010, lo_t[s]), oh});
    end else begin
      exp_q.push_back('{mkw(hdr_t[s], 3'b000, hi_t[s]), oh});
    end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || gq.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size() + gq.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_wren();
    int n = 0;
    while (!wren && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!wren) chk("wren_timeout", wren, 1);
  endtask

  // Producer model and scoreboard consumer.
  always @(negedge clk) begin
    if (!rst) begin
      if (wren) begin
        wq.push_back(cyc);
        if (exp_q.size() == 0) chk("wren_unexpected", wren, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("dataout", dataout, mon_e.data);
          chk("done", done, mon_e.done);
        end
      end else begin
        chk("done_idle", done, 0);
      end
      if (gnt != 3'b000) begin
        if (gq.size() == 0) chk("gnt_unexpected", gnt, 0);
        else chk("gnt", gnt, gq.pop_front());
        if (hold_all) begin
          rr_cnt++;
          if (rr_cnt == 6) req = 3'b000;
        end else begin
          req = req & ~gnt;
        end
      end
    end
  end

  initial begin
    int s;
    rst = 1'b1;
    full = 1'b0;
    req = 3'b000;
    two_beat = 3'b000;
    set_src(0, {2'b01, 3'b010}, 1'b0, 40'h00_0000_0A00, 40'h0);
    set_src(1, {2'b10, 3'b011}, 1'b0, 40'h00_0000_0B00, 40'h0);
    set_src(2, {2'b11, 3'b100}, 1'b0, 40'h00_0000_0C00, 40'h0);

    // Reset with all requests asserted, then continuous round-robin
    hold_all = 1'b1;
    req = 3'b111;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_wren", wren, 0);
      chk("rst_dataout", dataout, 0);
      chk("rst_gnt", gnt, 0);
    end
    for (int k = 0; k < 6; k++) begin
`ifdef DOUT_ARB_FIXED_PRIO_EN
      s = 0;
`else
      s = k % 3;
`endif
      push_pkt(s);
    end
    wq.delete();
    rst = 1'b0;
    drain(100);
    if (wq.size() == 6) begin
      for (int k = 1; k < 6; k++) chk("rr_spacing", 64'(wq[k] - wq[k-1]), 2);
    end else begin
      chk("rr_words", 64'(wq.size()), 6);
    end
    hold_all = 1'b0;

    // Single-beat packet from source 1
    set_src(1, {2'b10, 3'b001}, 1'b0, 40'h12345678_00, 40'hFFFF_FFFF_FF);
    gq.push_back(3'b010);
    exp_q.push_back('{{2'b10, 3'b001, 3'b000, 40'h1234567800}, 3'b010});
    wq.delete();
    req[1] = 1'b1;
    drain(50);
    chk("single_words", 64'(wq.size()), 1);

    // Two-beat packet from source 2 with backpressure after the first word
    set_src(2, {2'b01, 3'b110}, 1'b1, 40'hAA_AAAA_AAAA, 40'h55_5555_5555);
    push_pkt(2);
    wq.delete();
    req[2] = 1'b1;
    wait_wren();
    #1 full = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    full = 1'b0;
    drain(50);
    if (wq.size() == 2) chk("two_beat_gap", 64'(wq[1] - wq[0]), 4);
    else chk("two_beat_words", 64'(wq.size()), 2);

    // Reset while source 1 sits in the second beat
    set_src(1, {2'b00, 3'b101}, 1'b1, 40'h11_1111_1111, 40'h22_2222_2222);
    gq.push_back(3'b010);
    exp_q.push_back('{mkw(hdr_t[1], 3'b001, hi_t[1]), 3'b000});
    req[1] = 1'b1;
    wait_wren();
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_rst_pending", 64'(exp_q.size() + gq.size()), 0);

    // Arbitration must restart at source 0 (src1 was last before reset)
    set_src(0, {2'b11, 3'b111}, 1'b0, 40'h0F_0F0F_0F0F, 40'h0);
    set_src(2, {2'b10, 3'b000}, 1'b0, 40'hF0_F0F0_F0F0, 40'h0);
    push_pkt(0);
    push_pkt(2);
    req = 3'b101;
    drain(50);

    chk("final_pending", 64'(exp_q.size() + gq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
